// File: rtl/gate_checker_pkg.sv
// Purpose: shared types and constants for the 2-input gate checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gate_checker_pkg;

    // Checker sequencing states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Truth-table size and vector index width
    localparam int NUM_VECTORS = 4;
    localparam int VEC_W       = $clog2(NUM_VECTORS);

    // Width of the gate response bus
    localparam int Y_W = 6;

    // Bit positions inside the gate response bus
    localparam int Y_NOT_A = 0;
    localparam int Y_AND   = 1;
    localparam int Y_OR    = 2;
    localparam int Y_XOR   = 3;
    localparam int Y_NOR   = 4;
    localparam int Y_NAND  = 5;

    // Error counter width and saturation value
    localparam int          ERR_W   = 4;
    localparam logic [3:0]  ERR_MAX = 4'd15;

endpackage

// File: rtl/gate_expect.sv
// Purpose: golden response of the six reference gates for one input pair.
// Latency: purely combinational.
// Backpressure: none.
module gate_expect
    import gate_checker_pkg::*;
(
    input  logic           a,
    input  logic           b,
    output logic [Y_W-1:0] y_exp
);

    // Reference gate functions placed at their response-bus bit positions
    always_comb begin
        y_exp          = '0;
        y_exp[Y_NOT_A] = ~a;
        y_exp[Y_AND]   = a & b;
        y_exp[Y_OR]    = a | b;
        y_exp[Y_XOR]   = a ^ b;
        y_exp[Y_NOR]   = ~(a | b);
        y_exp[Y_NAND]  = ~(a & b);
    end

endmodule

// File: rtl/gate_checker.sv
// Purpose: sweeps a 2-input gate block through its truth table and grades the responses.
// Latency: done asserts in cycle 4*(SETTLE_CYCLES+2)*PASSES+1, counting the cycle after start is sampled as cycle 1.
// Backpressure: none; start is ignored unless the checker is idle.
module gate_checker
    import gate_checker_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic [Y_W-1:0]   y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [Y_W-1:0]   fail_mask
);

    // Settle counter holds up to SETTLE_CYCLES-1, pass counter up to PASSES-1
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;

    localparam logic [VEC_W-1:0] LAST_VEC    = VEC_W'(NUM_VECTORS - 1);
    localparam logic [SW-1:0]    SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
    localparam logic [PW-1:0]    LAST_PASS   = PW'(PASSES - 1);

    state_t             state_q,     state_d;
    logic [VEC_W-1:0]   vec_q,       vec_d;
    logic [SW-1:0]      settle_q,    settle_d;
    logic [PW-1:0]      pass_cnt_q,  pass_cnt_d;
    logic               a_q,         a_d;
    logic               b_q,         b_d;
    logic               busy_q,      busy_d;
    logic               done_q,      done_d;
    logic               pass_q,      pass_d;
    logic [ERR_W-1:0]   err_cnt_q,   err_cnt_d;
    logic [Y_W-1:0]     fail_mask_q, fail_mask_d;

    logic [Y_W-1:0]     y_exp;
    logic [Y_W-1:0]     mismatch;

    // Golden response follows the registered stimulus, so it is stable through SETTLE and CHECK
    gate_expect u_expect (
        .a     (a_q),
        .b     (b_q),
        .y_exp (y_exp)
    );

    assign mismatch = y ^ y_exp;

    // Next-state, counter and registered-output computation
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        settle_d    = settle_q;
        pass_cnt_d  = pass_cnt_q;
        pass_d      = pass_q;
        err_cnt_d   = err_cnt_q;
        fail_mask_d = fail_mask_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = DRIVE;
                    vec_d       = '0;
                    pass_cnt_d  = '0;
                    pass_d      = 1'b0;
                    err_cnt_d   = '0;
                    fail_mask_d = '0;
                end
            end
            DRIVE: begin
                state_d  = SETTLE;
                settle_d = SETTLE_LOAD;
            end
            SETTLE: begin
                if (settle_q == '0) begin
                    state_d = CHECK;
                end else begin
                    settle_d = settle_q - SW'(1);
                end
            end
            CHECK: begin
                // One error per failing vector regardless of how many bits differ
                if (|mismatch) begin
                    if (err_cnt_q != ERR_MAX) begin
                        err_cnt_d = err_cnt_q + ERR_W'(1);
                    end
                    fail_mask_d = fail_mask_q | mismatch;
                end
                if (vec_q == LAST_VEC) begin
                    vec_d      = '0;
                    pass_cnt_d = pass_cnt_q + PW'(1);
                    state_d    = (pass_cnt_q == LAST_PASS) ? DONE : DRIVE;
                end else begin
                    vec_d   = vec_q + VEC_W'(1);
                    state_d = DRIVE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they line up with state_q
        busy_d = (state_d == DRIVE) || (state_d == SETTLE) || (state_d == CHECK);
        done_d = (state_d == DONE);
        a_d    = busy_d & vec_d[1];
        b_d    = busy_d & vec_d[0];
        if (state_d == DONE) begin
            pass_d = (err_cnt_d == '0);
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            settle_q    <= '0;
            pass_cnt_q  <= '0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_cnt_q   <= '0;
            fail_mask_q <= '0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            settle_q    <= settle_d;
            pass_cnt_q  <= pass_cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_cnt_q   <= err_cnt_d;
            fail_mask_q <= fail_mask_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_cnt   = err_cnt_q;
    assign fail_mask = fail_mask_q;

endmodule

// File: tb/tb_gate_checker.sv
// Purpose: directed self-checking bench for gate_checker with a faultable gate model on y.
// Latency: cycle k is the k-th negedge after the edge that samples start.
// Backpressure: none.
module tb_gate_checker;

    localparam int LAT1  = 4 * (2 + 2) * 1 + 1;   // 17
    localparam int LAT4  = 4 * (2 + 2) * 4 + 1;   // 65
    localparam int BOUND = 200;

    logic       clk;
    logic       rst_n;
    logic       start,  start4;
    logic       a,      a4;
    logic       b,      b4;
    logic [5:0] y,      y4;
    logic       busy,   busy4;
    logic       done,   done4;
    logic       pass,   pass4;
    logic [3:0] err_cnt, err_cnt4;
    logic [5:0] fail_mask, fail_mask4;

    // 0: correct gates, 1: XOR output stuck at 0, 2: every output inverted
    logic [1:0] fault;

    int n_checks;
    int n_fail;

    gate_checker #(.SETTLE_CYCLES(2), .PASSES(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .y(y),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .fail_mask(fail_mask)
    );

    gate_checker #(.SETTLE_CYCLES(2), .PASSES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .y(y4),
        .busy(busy4), .done(done4), .pass(pass4), .err_cnt(err_cnt4), .fail_mask(fail_mask4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural gate block: {NAND, NOR, XOR, OR, AND, NOT a}
    function automatic logic [5:0] gate_model(input logic ia, input logic ib);
        return {~(ia & ib), ~(ia | ib), ia ^ ib, ia | ib, ia & ib, ~ia};
    endfunction

    // Gate block under test for the single-pass checker, with optional fault
    always_comb begin
        y = gate_model(a, b);
        if (fault == 2'd1) y[3] = 1'b0;
        else if (fault == 2'd2) y = ~gate_model(a, b);
    end

    // The multi-pass checker always sees a fully inverted gate block
    always_comb begin
        y4 = ~gate_model(a4, b4);
    end

    // Pulse start for one cycle; returns at the negedge of cycle 1
    task automatic pulse_start(input bit which);
        @(negedge clk);
        if (which) start4 = 1'b1; else start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        start4 = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0)  begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++; if (pass !== 1'b0)  begin n_fail++; $display("FAIL reset_pass got %b want 0", pass); end
        n_checks++; if ({a, b} !== 2'b00) begin n_fail++; $display("FAIL reset_ab got %b want 00", {a, b}); end
        n_checks++; if (err_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_err got %0d want 0", err_cnt); end
        n_checks++; if (fail_mask !== 6'b0) begin n_fail++; $display("FAIL reset_mask got %b want 000000", fail_mask); end
        n_checks++; if (busy4 !== 1'b0 || err_cnt4 !== 4'd0) begin n_fail++; $display("FAIL reset_dut4 got busy=%b err=%0d want 0/0", busy4, err_cnt4); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_clean_run;
        int k;
        logic [1:0] exp_ab;
        fault = 2'd0;
        pulse_start(0);
        k = 1;
        while (!done && k < BOUND) begin
            exp_ab = 2'((k - 1) / 4);
            n_checks++; if ({a, b} !== exp_ab) begin n_fail++; $display("FAIL clean_vector cycle %0d got %b want %b", k, {a, b}, exp_ab); end
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL clean_busy cycle %0d got %b want 1", k, busy); end
            @(negedge clk);
            k++;
        end
        n_checks++; if (!done || k != LAT1) begin n_fail++; $display("FAIL clean_latency got %0d (done=%b) want %0d", k, done, LAT1); end
        n_checks++; if (pass !== 1'b1) begin n_fail++; $display("FAIL clean_pass got %b want 1", pass); end
        n_checks++; if (err_cnt !== 4'd0) begin n_fail++; $display("FAIL clean_err got %0d want 0", err_cnt); end
        n_checks++; if (fail_mask !== 6'b000000) begin n_fail++; $display("FAIL clean_mask got %b want 000000", fail_mask); end
        n_checks++; if (busy !== 1'b0 || {a, b} !== 2'b00) begin n_fail++; $display("FAIL clean_done_idle got busy=%b ab=%b want 0/00", busy, {a, b}); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL clean_done_pulse got %b want 0", done); end
        n_checks++; if (pass !== 1'b1) begin n_fail++; $display("FAIL clean_pass_hold got %b want 1", pass); end
    endtask

    task automatic test_xor_stuck;
        int k;
        fault = 2'd1;
        pulse_start(0);
        // Accepted start clears the previous run's pass flag
        n_checks++; if (pass !== 1'b0) begin n_fail++; $display("FAIL xor_pass_cleared got %b want 0", pass); end
        k = 1;
        while (!done && k < BOUND) begin
            @(negedge clk);
            k++;
        end
        n_checks++; if (!done || k != LAT1) begin n_fail++; $display("FAIL xor_latency got %0d want %0d", k, LAT1); end
        n_checks++; if (err_cnt !== 4'd2) begin n_fail++; $display("FAIL xor_err got %0d want 2", err_cnt); end
        n_checks++; if (fail_mask !== 6'b001000) begin n_fail++; $display("FAIL xor_mask got %b want 001000", fail_mask); end
        n_checks++; if (pass !== 1'b0) begin n_fail++; $display("FAIL xor_pass got %b want 0", pass); end
        @(negedge clk);
    endtask

    task automatic test_saturate;
        int k;
        pulse_start(1);
        k = 1;
        while (!done4 && k < BOUND) begin
            @(negedge clk);
            k++;
        end
        n_checks++; if (!done4 || k != LAT4) begin n_fail++; $display("FAIL sat_latency got %0d want %0d", k, LAT4); end
        n_checks++; if (err_cnt4 !== 4'd15) begin n_fail++; $display("FAIL sat_err got %0d want 15", err_cnt4); end
        n_checks++; if (fail_mask4 !== 6'b111111) begin n_fail++; $display("FAIL sat_mask got %b want 111111", fail_mask4); end
        n_checks++; if (pass4 !== 1'b0) begin n_fail++; $display("FAIL sat_pass got %b want 0", pass4); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sat_other_idle got %b want 0", busy); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run;
        int k;
        bit seen_done;
        fault = 2'd1;
        pulse_start(0);
        k = 1;
        while (k < 10) begin
            @(negedge clk);
            k++;
        end
        // Cycle 10 is the first SETTLE cycle of vector 10; vector 01 has already failed
        n_checks++; if (err_cnt !== 4'd1 || {a, b} !== 2'b10) begin n_fail++; $display("FAIL midrst_pre got err=%0d ab=%b want 1/10", err_cnt, {a, b}); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end
        n_checks++; if ({a, b} !== 2'b00) begin n_fail++; $display("FAIL midrst_ab got %b want 00", {a, b}); end
        n_checks++; if (err_cnt !== 4'd0 || fail_mask !== 6'b0) begin n_fail++; $display("FAIL midrst_counts got err=%0d mask=%b want 0/000000", err_cnt, fail_mask); end
        seen_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (done || busy) seen_done = 1'b1;
            @(negedge clk);
        end
        n_checks++; if (seen_done) begin n_fail++; $display("FAIL midrst_no_done got activity want none"); end
        fault = 2'd0;
        pulse_start(0);
        k = 1;
        while (!done && k < BOUND) begin
            @(negedge clk);
            k++;
        end
        n_checks++; if (!done || k != LAT1) begin n_fail++; $display("FAIL midrst_rerun_latency got %0d want %0d", k, LAT1); end
        n_checks++; if (pass !== 1'b1 || err_cnt !== 4'd0) begin n_fail++; $display("FAIL midrst_rerun got pass=%b err=%0d want 1/0", pass, err_cnt); end
        @(negedge clk);
    endtask

    task automatic test_ignored_starts;
        int k;
        fault = 2'd1;
        pulse_start(0);
        k = 1;
        while (!done && k < BOUND) begin
            // Cycle 4 is the CHECK of vector 00
            start = (k == 4);
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        n_checks++; if (!done || k != LAT1) begin n_fail++; $display("FAIL ign_latency got %0d want %0d", k, LAT1); end
        n_checks++; if (err_cnt !== 4'd2 || fail_mask !== 6'b001000) begin n_fail++; $display("FAIL ign_counts got err=%0d mask=%b want 2/001000", err_cnt, fail_mask); end
        // Start during the DONE cycle
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL ign_done_restart got busy=%b done=%b want 0/0", busy, done); end
        n_checks++; if (err_cnt !== 4'd2 || pass !== 1'b0) begin n_fail++; $display("FAIL ign_done_counts got err=%0d pass=%b want 2/0", err_cnt, pass); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || {a, b} !== 2'b00) begin n_fail++; $display("FAIL ign_still_idle got busy=%b ab=%b want 0/00", busy, {a, b}); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        start4   = 1'b0;
        fault    = 2'd0;
        test_reset();
        test_clean_run();
        test_xor_stuck();
        test_saturate();
        test_reset_mid_run();
        test_ignored_starts();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gate_checker.md
GATE_CHECKER -- requirements
Module: gate_checker

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 2, which is the number of wait cycles (minimum 1) between driving a vector and sampling the response.
REQ-002 The block SHALL have parameter PASSES, default 1, which is the number of full truth-table sweeps per start (minimum 1).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit: begins a check run when sampled high in IDLE.
REQ-006 The block SHALL have ports a and b, output, 1 bit each: stimulus driven to the 2-input gate block under test.
REQ-007 The block SHALL have port y, input, 6 bits: response from the gate block; bit0=NOT a, bit1=AND, bit2=OR, bit3=XOR, bit4=NOR, bit5=NAND.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a run is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse at the end of a run.
REQ-010 The block SHALL have port pass, output, 1 bit: high when the last run had zero errors; valid from done and held until the next accepted start.
REQ-011 The block SHALL have port err_cnt, output, 4 bits: number of failing vectors, saturating at 15.
REQ-012 The block SHALL have port fail_mask, output, 6 bits: sticky OR of mismatching y bits over the run.

Function
REQ-013 The FSM SHALL have states IDLE, DRIVE, SETTLE, CHECK, DONE.
REQ-014 IDLE→DRIVE SHALL occur on start=1; in DRIVE, {a,b} SHALL take the vector index; the vector order SHALL be 00, 01, 10, 11.
REQ-015 DRIVE→SETTLE SHALL occur after 1 cycle; SETTLE SHALL last exactly SETTLE_CYCLES cycles under a down-counter and then go to CHECK.
REQ-016 CHECK SHALL last 1 cycle and compare y with expected = {~(a&b), ~(a|b), a^b, a|b, a&b, ~a}; any mismatch SHALL increment err_cnt by 1 (per vector, not per bit) and OR the mismatch bits into fail_mask.
REQ-017 After CHECK, the FSM SHALL go to DRIVE with the next vector; after vector 11, the pass counter SHALL increment, and the FSM SHALL go to DRIVE of vector 00 if passes remain, else to DONE.
REQ-018 DONE SHALL last 1 cycle with done=1, pass=(err_cnt==0), then return to IDLE.
REQ-019 Each vector SHALL take SETTLE_CYCLES+2 cycles; done SHALL be high exactly 4*(SETTLE_CYCLES+2)*PASSES+1 cycles after the edge that samples start.
REQ-020 busy SHALL be 1 in DRIVE/SETTLE/CHECK and 0 in IDLE/DONE.
REQ-021 start while busy, or in the DONE cycle, SHALL be ignored (no restart, no counter change).
REQ-022 An accepted start SHALL clear err_cnt, fail_mask and pass, and reset the vector and pass counters.
REQ-023 err_cnt at 15 SHALL hold at 15 on further failures; fail_mask SHALL continue to accumulate.
REQ-024 a and b SHALL be 0 in IDLE and DONE.

Reset
REQ-025 When rst_n=0 at a clock edge, the state SHALL become IDLE, a=b=0, busy=done=pass=0, err_cnt=0, fail_mask=0, and all counters 0.
REQ-026 Reset asserted mid-run SHALL abort the run with no done pulse; the first start after rst_n returns high SHALL start a fresh run.

Structure
REQ-027 Package gate_checker_pkg SHALL hold the state enum, the constant NUM_VECTORS=4, the output width constant 6, and the bit-index constants for y.
REQ-028 Sub-module gate_expect (combinational: a,b → 6-bit expected) SHALL be instantiated once; all other logic SHALL reside in gate_checker.

Verification
REQ-029 With a correct gate model on y, SETTLE_CYCLES=2, PASSES=1, and start pulsed, done SHALL arrive 17 cycles later with pass=1, err_cnt=0, fail_mask=6'b000000.
REQ-030 With y[3] stuck at 0, a run SHALL report failures at vectors 01 and 10: err_cnt=2, fail_mask=6'b001000, pass=0.
REQ-031 With all y bits inverted and PASSES=4, 16 failing vectors SHALL give err_cnt=15 (saturated), fail_mask=6'b111111, pass=0.
REQ-032 With rst_n=0 for one cycle during SETTLE of vector 10, the next cycle SHALL show busy=0, a=b=0, err_cnt=0, and no done pulse; a new start SHALL then complete normally.
REQ-033 start pulses during CHECK and during the DONE cycle SHALL be ignored, so done timing and counts equal those of a single-start run.
